gecko_reg_scoreboard: RTL and testbench
=======================================

# gecko_reg_scoreboard

Per-register outstanding-write tracker for the gecko core. It sits directly upstream of decode and supplies the 32-entry register status array that decode uses for operand readiness and rd writeability checks. Decode increments an entry when it issues a writeback instruction. The writeback stage decrements it when the result retires.

## Interface
Parameters:
- COUNTER_WIDTH, 2, bits per register counter; MAX = 2^COUNTER_WIDTH − 1 outstanding writes per register.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode issued an instruction that writes back (does_opcode_writeback true)
- issue_addr  in  5  rd of the issued instruction
- retire_valid  in  1  writeback stage committed a register write
- retire_addr  in  5  rd of the retired write
- flush  in  1  synchronous clear of all counters (pipeline drained/redirected)
- reg_status  out  32 × gecko_reg_status_t  per-register status to decode
- pending_count  out  6  number of registers with nonzero counter (0..31)
- idle  out  1  all counters zero
- error  out  1  sticky protocol-violation flag

## Operation
- One counter per register x1..x31. x0 has no counter: reg_status[0] is hard VALID, and issue/retire to address 0 are ignored.
- Status encoding from count c: c==0 → GECKO_REG_STATUS_VALID; 0<c<MAX → GECKO_REG_STATUS_PENDING; c==MAX → GECKO_REG_STATUS_FULL.
- Per-register next count, in priority order:
  - flush → 0.
  - issue and retire hit the same register → unchanged.
  - issue only → c+1.
  - retire only → c−1.
- Issue to a FULL register saturates at MAX and sets error. Decode must never do this; is_register_writeable blocks it.
- Retire to a register with c==0 holds at 0 and sets error.
- When flush and issue/retire fall in the same cycle, flush wins. Issue and retire are dropped, and no error is raised.
- error is cleared only by rst.
- pending_count and idle are registered and derived from the next-state counters. They are coherent with reg_status in the same cycle.

## Timing
- Reset values: all counters 0, reg_status all VALID, pending_count 0, idle 1, error 0.
- Issue latency: an issue in cycle N is visible in reg_status at cycle N+1. Decode therefore cannot issue two writes to the same rd back-to-back past the FULL limit.
- Retire latency: 1 cycle (N+1) by default. With the bypass macro it is 0 cycles (see Configuration).
- reg_status, pending_count, idle and error change only on clk rising edge. The exception is the bypass path.
- When rst is asserted mid-operation, all state clears immediately (asynchronous). The first update is accepted on the first clk edge after deassertion.

## Configuration
- GECKO_SCOREBOARD_BYPASS_EN defined:
  - reg_status[retire_addr] is computed combinationally from c−1 while retire_valid is high.
  - Example: a register at c==1 with a retire in the same cycle reads VALID.
  - Decode may then issue its dependent in the same cycle; the operand is forwarded by writeback.
  - Bypass is suppressed when flush is high or retire_addr==0.
- Undefined: reg_status is purely registered, and a retire becomes visible the following cycle.
- All counting, flush and error behaviour is identical in both builds.

## Structure
- gecko package already holds gecko_reg_status_t. Add to it:
  - gecko_scoreboard_count_t (logic [COUNTER_WIDTH-1:0]).
  - A function mapping count → gecko_reg_status_t, shared with the bypass path.
- gecko_decode_util keeps its gecko_decode_reg_file_status_t typedef. reg_status is type-compatible with it.
- Sub-module gecko_scoreboard_entry holds one saturating up/down counter and is instantiated 31× via generate. Its ports:
  - inc, dec, clear, count out, over/underflow pulses.
- Top level handles:
  - Address decode.
  - Error OR-reduction.
  - Popcount for pending_count.
  - Optional bypass mux.

## Test plan
- Reset, no stimulus → reg_status all VALID, idle=1, pending_count=0, error=0.
- Issue x5 three times (COUNTER_WIDTH=2):
  - After 1st: reg_status[5]=PENDING, pending_count=1, idle=0.
  - After 3rd: FULL.
  - Three retires of x5 → VALID, idle=1.
- Same-cycle issue+retire of x7 at c==1 → c stays 1, status PENDING, no error.
- Retire x9 at c==0 → reg_status[9] stays VALID, error=1 and stays 1 until rst.
- Issue x3,x4,x6 over three cycles, then flush asserted with issue x8 in the same cycle → all VALID, pending_count=0, x8 not counted.
- Bypass build: x10 at c==1, retire x10 → reg_status[10]=VALID in the same cycle. Non-bypass build → VALID one cycle later. Issue/retire to x0 in either build → no change, no error.

Source files
------------

// File: rtl/gecko_reg_scoreboard_pkg.sv
// Shared types for the gecko register scoreboard.
// Status encoding, counter type and count->status mapping.
package gecko_reg_scoreboard_pkg;

  localparam int GECKO_SB_COUNTER_WIDTH = 2;

  typedef enum logic [1:0] {
    GECKO_REG_STATUS_VALID   = 2'd0,
    GECKO_REG_STATUS_PENDING = 2'd1,
    GECKO_REG_STATUS_FULL    = 2'd2
  } gecko_reg_status_t;

  typedef logic [GECKO_SB_COUNTER_WIDTH-1:0] gecko_scoreboard_count_t;

  typedef gecko_reg_status_t [31:0] gecko_decode_reg_file_status_t;

  // Width is passed in so the same mapping serves any counter size.
  function automatic gecko_reg_status_t gecko_count_status(
    input logic [7:0]  c,
    input int unsigned w
  );
    logic [7:0] m;
    m = 8'hFF >> (8 - w);
    if (c == 8'd0)
      return GECKO_REG_STATUS_VALID;
    else if (c == m)
      return GECKO_REG_STATUS_FULL;
    return GECKO_REG_STATUS_PENDING;
  endfunction

endpackage

// File: rtl/gecko_reg_scoreboard_entry.sv
// One saturating up/down outstanding-write counter.
// Emits one-cycle over/underflow pulses; clear suppresses them.
module gecko_scoreboard_entry #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         over,
  output logic         under
);

  localparam logic [W-1:0] MAX = '1;

  always_comb begin
    count_next = count;
    over       = 1'b0;
    under      = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (inc && !dec) begin
      if (count == MAX)
        over = 1'b1;
      else
        count_next = count + 1'b1;
    end else if (dec && !inc) begin
      if (count == '0)
        under = 1'b1;
      else
        count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Per-register outstanding-write scoreboard feeding decode.
// Define GECKO_SCOREBOARD_BYPASS_EN for same-cycle retire visibility.
module gecko_reg_scoreboard
  import gecko_reg_scoreboard_pkg::*;
#(
  parameter int COUNTER_WIDTH = GECKO_SB_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_addr,
  input  logic                     retire_valid,
  input  logic [4:0]               retire_addr,
  input  logic                     flush,
  output gecko_reg_status_t [31:0] reg_status,
  output logic [5:0]               pending_count,
  output logic                     idle,
  output logic                     error
);

  localparam int W = COUNTER_WIDTH;

  logic [31:1][W-1:0] cnt;
  logic [31:1][W-1:0] cnt_nxt;
  logic [31:1]        over;
  logic [31:1]        under;
  logic [31:1]        live;
  logic [5:0]         pc_nxt;

  for (genvar i = 1; i < 32; i++) begin : g_ent
    logic inc;
    logic dec;
    assign inc = issue_valid && (issue_addr == 5'(i));
    assign dec = retire_valid && (retire_addr == 5'(i));

    gecko_scoreboard_entry #(.W(W)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc),
      .dec        (dec),
      .clear      (flush),
      .count      (cnt[i]),
      .count_next (cnt_nxt[i]),
      .over       (over[i]),
      .under      (under[i])
    );

    assign live[i] = |cnt_nxt[i];
  end

`ifdef GECKO_SCOREBOARD_BYPASS_EN
  logic [31:0][W-1:0] cnt_all;
  logic [W-1:0]       cnt_sel;
  logic [W-1:0]       cnt_dec;
  assign cnt_all = {cnt, {W{1'b0}}};
  assign cnt_sel = cnt_all[retire_addr];
  assign cnt_dec = (cnt_sel == '0) ? '0 : cnt_sel - 1'b1;
`endif

  always_comb begin
    reg_status[0] = GECKO_REG_STATUS_VALID;
    for (int i = 1; i < 32; i++)
      reg_status[i] = gecko_count_status(8'(cnt[i]), W);
`ifdef GECKO_SCOREBOARD_BYPASS_EN
    // Retiring write is forwarded, so its reader may issue now.
    if (retire_valid && !flush && retire_addr != 5'd0)
      reg_status[retire_addr] = gecko_count_status(8'(cnt_dec), W);
`endif
  end

  always_comb begin
    pc_nxt = '0;
    for (int i = 1; i < 32; i++)
      pc_nxt = pc_nxt + 6'(live[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_count <= '0;
      idle          <= 1'b1;
      error         <= 1'b0;
    end else begin
      pending_count <= pc_nxt;
      idle          <= ~|live;
      error         <= error | (|over) | (|under);
    end
  end

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Directed table-driven bench for gecko_reg_scoreboard.
// Expectation for the retire bypass follows GECKO_SCOREBOARD_BYPASS_EN.
module tb_gecko_reg_scoreboard;
  import gecko_reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic issue_valid;
  logic [4:0] issue_addr;
  logic retire_valid;
  logic [4:0] retire_addr;
  logic flush;
  gecko_reg_status_t [31:0] reg_status;
  logic [5:0] pending_count;
  logic idle;
  logic error;

  int total = 0;
  int bad = 0;

  gecko_reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .retire_valid  (retire_valid),
    .retire_addr   (retire_addr),
    .flush         (flush),
    .reg_status    (reg_status),
    .pending_count (pending_count),
    .idle          (idle),
    .error         (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [4:0]        ia;
    logic              rv;
    logic [4:0]        ra;
    logic              fl;
    int                idx;
    gecko_reg_status_t st;
    int                pc;
    logic              idl;
    logic              err;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ia,
    input logic rv, input logic [4:0] ra,
    input logic fl, input int idx,
    input gecko_reg_status_t st, input int pc,
    input logic idl, input logic err
  );
    vec_t v;
    v.iv = iv; v.ia = ia; v.rv = rv; v.ra = ra; v.fl = fl;
    v.idx = idx; v.st = st; v.pc = pc; v.idl = idl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic iv, input logic [4:0] ia,
    input logic rv, input logic [4:0] ra, input logic fl
  );
    @(negedge clk);
    issue_valid  = iv;
    issue_addr   = ia;
    retire_valid = rv;
    retire_addr  = ra;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    issue_valid  = 1'b0;
    issue_addr   = 5'd0;
    retire_valid = 1'b0;
    retire_addr  = 5'd0;
    flush        = 1'b0;
    #1;
  endtask

  task automatic op(
    input logic iv, input logic [4:0] ia,
    input logic rv, input logic [4:0] ra, input logic fl
  );
    drive(iv, ia, rv, ra, fl);
    step();
  endtask

  localparam gecko_reg_status_t V = GECKO_REG_STATUS_VALID;
  localparam gecko_reg_status_t P = GECKO_REG_STATUS_PENDING;
  localparam gecko_reg_status_t F = GECKO_REG_STATUS_FULL;

  gecko_reg_status_t byp_exp;

  initial begin
    vt[0]  = mk(1, 5,  0, 0,  0, 5,  P, 1, 0, 0);
    vt[1]  = mk(1, 5,  0, 0,  0, 5,  P, 1, 0, 0);
    vt[2]  = mk(1, 5,  0, 0,  0, 5,  F, 1, 0, 0);
    vt[3]  = mk(0, 0,  1, 5,  0, 5,  P, 1, 0, 0);
    vt[4]  = mk(0, 0,  1, 5,  0, 5,  P, 1, 0, 0);
    vt[5]  = mk(0, 0,  1, 5,  0, 5,  V, 0, 1, 0);
    vt[6]  = mk(1, 7,  0, 0,  0, 7,  P, 1, 0, 0);
    vt[7]  = mk(1, 7,  1, 7,  0, 7,  P, 1, 0, 0);
    vt[8]  = mk(1, 0,  0, 0,  0, 0,  V, 1, 0, 0);
    vt[9]  = mk(0, 0,  1, 0,  0, 0,  V, 1, 0, 0);
    vt[10] = mk(0, 0,  1, 7,  0, 7,  V, 0, 1, 0);
    vt[11] = mk(1, 3,  0, 0,  0, 3,  P, 1, 0, 0);
    vt[12] = mk(1, 4,  0, 0,  0, 4,  P, 2, 0, 0);
    vt[13] = mk(1, 6,  0, 0,  0, 6,  P, 3, 0, 0);
    vt[14] = mk(1, 8,  0, 0,  1, 8,  V, 0, 1, 0);
    vt[15] = mk(0, 0,  0, 0,  0, 3,  V, 0, 1, 0);
    vt[16] = mk(0, 0,  1, 9,  0, 9,  V, 0, 1, 1);
    vt[17] = mk(0, 0,  0, 0,  1, 9,  V, 0, 1, 1);

    rst = 1'b0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    retire_valid = 1'b0; retire_addr = 5'd0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rst_status%0d", i), int'(reg_status[i]), int'(V));
    chk("rst_pc", int'(pending_count), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_err", int'(error), 0);
    rst = 1'b1;

    for (int k = 0; k < 18; k++) begin
      op(vt[k].iv, vt[k].ia, vt[k].rv, vt[k].ra, vt[k].fl);
      chk($sformatf("v%0d_status", k),
          int'(reg_status[vt[k].idx]), int'(vt[k].st));
      chk($sformatf("v%0d_pc", k), int'(pending_count), vt[k].pc);
      chk($sformatf("v%0d_idle", k), int'(idle), int'(vt[k].idl));
      chk($sformatf("v%0d_err", k), int'(error), int'(vt[k].err));
    end

    // Asynchronous reset mid-operation clears everything at once.
    op(1, 12, 0, 0, 0);
    chk("pre_rst_x12", int'(reg_status[12]), int'(P));
    rst = 1'b0;
    #1;
    chk("arst_x12", int'(reg_status[12]), int'(V));
    chk("arst_pc", int'(pending_count), 0);
    chk("arst_idle", int'(idle), 1);
    chk("arst_err", int'(error), 0);
    @(negedge clk);
    rst = 1'b1;

    // Retire to an empty register under flush raises no error.
    op(0, 0, 1, 9, 1);
    chk("flush_under_err", int'(error), 0);

    // Retire visibility: same cycle with bypass, next cycle without.
    op(1, 10, 0, 0, 0);
    drive(0, 0, 1, 10, 0);
    #1;
`ifdef GECKO_SCOREBOARD_BYPASS_EN
    byp_exp = V;
`else
    byp_exp = P;
`endif
    chk("byp_same_cycle", int'(reg_status[10]), int'(byp_exp));
    step();
    chk("byp_next_cycle", int'(reg_status[10]), int'(V));
    chk("byp_err", int'(error), 0);

    // Flush suppresses the bypass view.
    op(1, 11, 0, 0, 0);
    drive(0, 0, 1, 11, 1);
    #1;
    chk("byp_flush_same", int'(reg_status[11]), int'(P));
    step();
    chk("byp_flush_next", int'(reg_status[11]), int'(V));
    chk("byp_flush_pc", int'(pending_count), 0);

    // Saturation at MAX and overflow error.
    op(1, 13, 0, 0, 0);
    op(1, 13, 0, 0, 0);
    op(1, 13, 0, 0, 0);
    chk("sat_full", int'(reg_status[13]), int'(F));
    chk("sat_err0", int'(error), 0);
    op(1, 13, 0, 0, 0);
    chk("sat_hold", int'(reg_status[13]), int'(F));
    chk("sat_err1", int'(error), 1);
    op(0, 0, 1, 13, 0);
    chk("sat_dec", int'(reg_status[13]), int'(P));
    chk("sat_pc", int'(pending_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
